// File: rtl/id_ex_stage.sv
// Decode stage of the 5-stage RISC-V core: operand read with write-back bypass,
// immediate generation, load-use detection and the ID/EX pipeline register.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_mem_read,
    output logic        ex_reg_write
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]  opcode;
    logic        rs1_used;
    logic        rs2_used;
    logic        reg_write_next;
    logic        mem_read_next;
    logic        hazard;
    logic [31:0] op1_next;
    logic [31:0] op2_next;
    logic [31:0] imm_next;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    assign rs1_used       = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs2_used       = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
    assign reg_write_next = !(opcode == OP_STORE || opcode == OP_BRANCH);
    assign mem_read_next  = (opcode == OP_LOAD);

    // The register file only shows a write after the edge, so merge it here.
    assign op1_next = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_data1;
    assign op2_next = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_data2;

    always_comb begin
        imm_next = 32'd0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm_next = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE:
                imm_next = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                imm_next = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_next = {if_instr[31:12], 12'd0};
            OP_JAL:
                imm_next = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            default:
                imm_next = 32'd0;
        endcase
    end

    assign hazard = if_valid && ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                    ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

    // A taken branch overwrites IF/ID anyway, so stalling it would be pointless.
    assign id_stall = hazard && !ex_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= 32'd0;
            ex_op1       <= 32'd0;
            ex_op2       <= 32'd0;
            ex_imm       <= 32'd0;
            ex_rd        <= 5'd0;
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_opcode    <= 7'd0;
            ex_funct3    <= 3'd0;
            ex_funct7b5  <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (ex_flush || hazard || !if_valid) begin
            // Bubble: data fields hold, only control and the destination clear.
            ex_valid     <= 1'b0;
            ex_rd        <= 5'd0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_op1       <= op1_next;
            ex_op2       <= op2_next;
            ex_imm       <= imm_next;
            ex_rd        <= if_instr[11:7];
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_opcode    <= opcode;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_mem_read  <= mem_read_next;
            ex_reg_write <= reg_write_next;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, immediates, bypass, load-use stall,
// flush priority, stores, bubbles and synchronous reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_mem_read, ex_reg_write;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI = 32'hFFC08293;  // addi x5, x1, -4
    localparam logic [31:0] I_BEQ  = 32'hFE208CE3;  // beq x1, x2, -8
    localparam logic [31:0] I_ADD4 = 32'h00318233;  // add x4, x3, x3
    localparam logic [31:0] I_ADD0 = 32'h00000233;  // add x4, x0, x0
    localparam logic [31:0] I_LW   = 32'h0000A103;  // lw x2, 0(x1)
    localparam logic [31:0] I_ADD6 = 32'h00710333;  // add x6, x2, x7
    localparam logic [31:0] I_LUI  = 32'h00010137;  // lui x2, 0x10 (rs1 field = 2)
    localparam logic [31:0] I_SW   = 32'h00942623;  // sw x9, 12(x8)

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h100;
        rf_data1 = 32'd10; rf_data2 = 32'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; ex_flush = 1'b0;

        // Reset held for two edges with a valid instruction present
        tick(); tick();
        chk("rst_valid",     {31'd0, ex_valid},     32'd0);
        chk("rst_pc",        ex_pc,                 32'd0);
        chk("rst_op1",       ex_op1,                32'd0);
        chk("rst_imm",       ex_imm,                32'd0);
        chk("rst_rd",        {27'd0, ex_rd},        32'd0);
        chk("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_stall",     {31'd0, id_stall},     32'd0);
        chk("rs1_comb",      {27'd0, rs1},          32'd1);
        $display("reset: ex_valid=%0d id_stall=%0d", ex_valid, id_stall);

        // ADDI captured one edge after reset release
        rst = 1'b0;
        tick();
        chk("addi_valid",  {31'd0, ex_valid},     32'd1);
        chk("addi_pc",     ex_pc,                 32'h100);
        chk("addi_op1",    ex_op1,                32'd10);
        chk("addi_imm",    ex_imm,                32'hFFFFFFFC);
        chk("addi_rd",     {27'd0, ex_rd},        32'd5);
        chk("addi_rs1",    {27'd0, ex_rs1},       32'd1);
        chk("addi_opcode", {25'd0, ex_opcode},    32'h13);
        chk("addi_rw",     {31'd0, ex_reg_write}, 32'd1);
        chk("addi_mr",     {31'd0, ex_mem_read},  32'd0);
        $display("addi: op1=%h imm=%h rd=%0d", ex_op1, ex_imm, ex_rd);

        // BEQ, negative B-type offset
        issue(I_BEQ, 32'h104);
        tick();
        chk("beq_imm", ex_imm,                 32'hFFFFFFF8);
        chk("beq_rw",  {31'd0, ex_reg_write}, 32'd0);
        $display("beq: imm=%h reg_write=%0d", ex_imm, ex_reg_write);

        // Write-back bypass on both operands
        issue(I_ADD4, 32'h108);
        rf_data1 = 32'd0; rf_data2 = 32'd0;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        tick();
        chk("byp_op1",    ex_op1,                32'hDEADBEEF);
        chk("byp_op2",    ex_op2,                32'hDEADBEEF);
        chk("byp_funct7", {31'd0, ex_funct7b5}, 32'd0);
        $display("bypass: op1=%h op2=%h", ex_op1, ex_op2);

        // wb_rd = 0 must never bypass
        issue(I_ADD0, 32'h10C);
        wb_rd = 5'd0;
        tick();
        chk("x0_op1", ex_op1, 32'd0);
        chk("x0_op2", ex_op2, 32'd0);
        $display("x0 write: op1=%h op2=%h", ex_op1, ex_op2);
        wb_we = 1'b0;

        // Load-use: one bubble, then the dependent ADD is captured
        issue(I_LW, 32'h200);
        tick();
        chk("lw_mr", {31'd0, ex_mem_read}, 32'd1);
        chk("lw_rd", {27'd0, ex_rd},       32'd2);
        issue(I_ADD6, 32'h204);
        rf_data1 = 32'h22; rf_data2 = 32'h77;
        #1;
        chk("lu_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid},    32'd0);
        chk("lu_bubble_rd",    {27'd0, ex_rd},       32'd0);
        chk("lu_bubble_mr",    {31'd0, ex_mem_read}, 32'd0);
        chk("lu_stall_clear",  {31'd0, id_stall},    32'd0);
        $display("load-use: bubble ex_valid=%0d id_stall=%0d", ex_valid, id_stall);
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rd",    {27'd0, ex_rd},    32'd6);
        chk("lu_add_rs2",   {27'd0, ex_rs2},   32'd7);
        chk("lu_add_op2",   ex_op2,            32'h77);
        $display("load-use: add captured rd=%0d", ex_rd);

        // LW x2 then LUI x2: rs1 field matches but LUI does not read rs1
        issue(I_LW, 32'h300);
        tick();
        issue(I_LUI, 32'h304);
        #1;
        chk("lui_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("lui_valid", {31'd0, ex_valid}, 32'd1);
        chk("lui_imm",   ex_imm,            32'h00010000);
        $display("lui after lw: stall=0 imm=%h", ex_imm);

        // Flush and hazard together: flush wins
        issue(I_LW, 32'h400);
        tick();
        issue(I_ADD6, 32'h404);
        ex_flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, ex_valid},     32'd0);
        chk("flush_rw",    {31'd0, ex_reg_write}, 32'd0);
        ex_flush = 1'b0;
        $display("flush+hazard: stall=0 ex_valid=%0d", ex_valid);

        // Store with rs2 bypass
        issue(I_SW, 32'h500);
        rf_data1 = 32'h1000; rf_data2 = 32'd5;
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'hCAFEF00D;
        tick();
        chk("sw_valid",  {31'd0, ex_valid},     32'd1);
        chk("sw_rw",     {31'd0, ex_reg_write}, 32'd0);
        chk("sw_imm",    ex_imm,                32'd12);
        chk("sw_op1",    ex_op1,                32'h1000);
        chk("sw_op2",    ex_op2,                32'hCAFEF00D);
        chk("sw_funct3", {29'd0, ex_funct3},    32'd2);
        wb_we = 1'b0;
        $display("store: imm=%h op2=%h", ex_imm, ex_op2);

        // No valid instruction: bubble
        if_valid = 1'b0;
        tick();
        chk("idle_valid", {31'd0, ex_valid}, 32'd0);
        chk("idle_rd",    {27'd0, ex_rd},    32'd0);
        $display("idle: ex_valid=%0d", ex_valid);

        // Mid-run synchronous reset discards a captured instruction
        issue(I_ADDI, 32'h600);
        rf_data1 = 32'd10;
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_sync_hold", {31'd0, ex_valid}, 32'd1);
        tick();
        chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_pc",    ex_pc,             32'd0);
        chk("mid_rst_imm",   ex_imm,            32'd0);
        $display("mid-run reset: ex_valid=%0d pc=%h", ex_valid, ex_pc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-side pipeline stage of the 5-stage RISC-V core, directly downstream of the register file. It drives the register-file read addresses, merges same-cycle write-back data into the operands, generates the immediate, detects load-use hazards, and registers the result into the ID/EX pipeline register consumed by the execute stage. It also owns bubble insertion and branch-flush squashing for the ID/EX boundary.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF/ID holds a real instruction.
- if_instr  in  32  instruction word from IF/ID.
- if_pc  in  32  PC of if_instr.
- rs1, rs2  out  5  register-file read addresses, combinational from if_instr[19:15] and if_instr[24:20].
- rf_data1, rf_data2  in  32  register-file asynchronous read data; x0 already reads 0.
- wb_we, wb_rd, wb_data  in  1/5/32  write-back port; same signals that drive the register-file write.
- ex_flush  in  1  branch/jump resolved taken in EX; squash the instruction in ID.
- id_stall  out  1  combinational; holds PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc, ex_op1, ex_op2, ex_imm  out  32  registered PC, operands and immediate.
- ex_rd, ex_rs1, ex_rs2  out  5  registered register indices for EX forwarding.
- ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1  registered decode fields.
- ex_mem_read, ex_reg_write  out  1  registered control; 0 whenever ex_valid is 0.

## Operation
- Use flags by opcode: rs1 used for all except LUI (0110111), AUIPC (0010111), JAL (1101111). rs2 used only for R (0110011), S (0100011), B (1100011).
- ex_reg_write = 1 for all opcodes except S and B. ex_mem_read = 1 only for LOAD (0000011).
- Write-back bypass: op1 = wb_data if wb_we && wb_rd != 0 && wb_rd == rs1, else rf_data1; same for op2/rs2. This covers the register file not yet showing a write issued in the same cycle.
- Immediate, sign-extended to 32 bits:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0 = 0.
  - U: LUI/AUIPC, low 12 bits 0.
  - J: JAL, bit0 = 0.
  - Any other opcode gives 0.
- Load-use hazard = if_valid && ex_valid && ex_mem_read && ex_rd != 0 && ((rs1 used && ex_rd == rs1) || (rs2 used && ex_rd == rs2)).
- id_stall = hazard && !ex_flush.
- Next-state priority per edge:
  1. rst: all ID/EX fields 0.
  2. ex_flush: ex_valid, ex_mem_read, ex_reg_write set to 0 (bubble).
  3. Hazard: bubble; IF/ID is held by id_stall, so the same instruction is re-evaluated next cycle.
  4. if_valid = 0: bubble.
  5. Otherwise capture all fields, with ex_valid = 1.
- In a bubble, data fields (pc/op/imm/indices) may hold any value, but ex_rd is forced to 0.

## Timing
- All outputs reset to 0. The reset is synchronous: a reset asserted mid-operation discards the ID/EX contents at the next edge.
- Latency: an instruction present in IF/ID at edge N appears on ex_* after edge N (one cycle).
- Load-use: exactly one bubble is inserted. On the following cycle the load is in MEM, so the hazard clears and the dependent instruction is captured with ex_valid = 1. The load value is forwarded by EX/MEM logic outside this block.
- A dependent instruction three stages behind a write is captured with wb_data through the bypass, in the same cycle as the write.
- When ex_flush and hazard occur together, the flush wins: id_stall = 0 and a bubble is inserted. The fetch redirect overwrites IF/ID.
- rs1/rs2 and id_stall are combinational from the current inputs. There is no registered path from them.

## Test plan
- Reset: assert rst for 2 cycles with if_valid = 1 → all ex_* = 0 and id_stall = 0. Release → the first instruction is captured after one edge.
- Capture plus immediate: ADDI x5, x1, -4 (0xFFC08293) with rf_data1 = 10 → ex_op1 = 10, ex_imm = 0xFFFFFFFC, ex_rd = 5, ex_reg_write = 1. BEQ with offset -8 → ex_imm = 0xFFFFFFF8.
- Bypass: wb_we = 1, wb_rd = 3, wb_data = 0xDEADBEEF, ADD x4, x3, x3, rf_data = 0 → ex_op1 = ex_op2 = 0xDEADBEEF. With wb_rd = 0 → operands = rf_data.
- Load-use: LW x2 then ADD x6, x2, x7 → one cycle with id_stall = 1 and ex_valid = 0, then ADD captured. LW x2 then LUI x2 → no stall.
- Flush priority: hazard and ex_flush asserted in the same cycle → id_stall = 0 and ex_valid = 0 next cycle.
- Store: SW x9, 12(x8) → ex_reg_write = 0, ex_imm = 12, and rs2 bypass applies when wb_rd = 9.
